lc3_mem_arbiter: RTL and testbench

- Shares the single-port LC-3 main memory between two requesters: the core control unit (MIO_EN/R.W/MAR/MDR with R-ready) and a DMA/I/O engine (req/ack).
- Sits between the core's memory-interface signals and the memory module; it replaces the core's direct connection.
- Serialises accesses with round-robin on ties, registers the granted command toward memory, and returns a one-cycle ready per requester.
- Aborts a hung memory access after a programmable timeout.

---
 rtl/lc3_pkg.sv | 18 +
 rtl/lc3_rr_arb2.sv | 23 ++
 rtl/lc3_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lc3_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared types and default widths for the LC-3 memory arbiter.
package lc3_pkg;

    localparam int unsigned LC3_ADDR_W = 16;
    localparam int unsigned LC3_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } arb_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DMA
    } grant_t;

endpackage

// File: rtl/lc3_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not served last wins.
module lc3_rr_arb2
    import lc3_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   dma_req_i,
    input  grant_t last_grant_i,
    output logic   valid_o,
    output grant_t grant_o
);

    // Purely combinational priority flip based on who was served last.
    always_comb begin
        valid_o = cpu_req_i | dma_req_i;
        grant_o = GNT_CPU;
        if (cpu_req_i && dma_req_i) begin
            grant_o = (last_grant_i == GNT_DMA) ? GNT_CPU : GNT_DMA;
        end else if (dma_req_i) begin
            grant_o = GNT_DMA;
        end
    end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 memory between the core and a DMA engine.
// One access at a time: IDLE arbitrates, BUSY holds the registered command until
// mem_rdy or timeout, RESP issues a one-cycle ready to the owner.
module lc3_mem_arbiter
    import lc3_pkg::*;
#(
    parameter int unsigned ADDR_W  = LC3_ADDR_W,
    parameter int unsigned DATA_W  = LC3_DATA_W,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_mio_en,
    input  logic              cpu_r_w,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_r,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              timeout_err,
    output logic              busy
);

    // Counter wide enough to reach TIMEOUT-1 for any TIMEOUT value.
    localparam int unsigned     CntW    = $clog2(TIMEOUT + 2);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    grant_t            last_grant_q, last_grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cpu_r_q, cpu_r_d;
    logic              dma_ack_q, dma_ack_d;
    logic              timeout_err_q, timeout_err_d;
    logic              busy_q;

    logic              arb_valid;
    grant_t            arb_grant;

    lc3_rr_arb2 u_arb (
        .cpu_req_i    (cpu_mio_en),
        .dma_req_i    (dma_req),
        .last_grant_i (last_grant_q),
        .valid_o      (arb_valid),
        .grant_o      (arb_grant)
    );

    // Next-state, command capture, completion and ready generation.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        cpu_r_d       = 1'b0;
        dma_ack_d     = 1'b0;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                // mem_rdy here is stale (e.g. after a reset) and deliberately ignored.
                if (arb_valid) begin
                    last_grant_d = arb_grant;
                    cnt_d        = '0;
                    mem_en_d     = 1'b1;
                    if (arb_grant == GNT_CPU) begin
                        mem_we_d    = cpu_r_w;
                        mem_addr_d  = cpu_addr;
                        mem_wdata_d = cpu_wdata;
                    end else begin
                        mem_we_d    = dma_we;
                        mem_addr_d  = dma_addr;
                        mem_wdata_d = dma_wdata;
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                // mem_rdy takes priority over a timeout landing on the same cycle.
                if (mem_rdy) begin
                    mem_en_d = 1'b0;
                    if (!mem_we_q) begin
                        if (last_grant_q == GNT_CPU) cpu_rdata_d = mem_rdata;
                        else                         dma_rdata_d = mem_rdata;
                    end
                    cpu_r_d   = (last_grant_q == GNT_CPU);
                    dma_ack_d = (last_grant_q == GNT_DMA);
                    state_d   = RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    mem_en_d = 1'b0;
                    if (last_grant_q == GNT_CPU) cpu_rdata_d = '0;
                    else                         dma_rdata_d = '0;
                    cpu_r_d       = (last_grant_q == GNT_CPU);
                    dma_ack_d     = (last_grant_q == GNT_DMA);
                    timeout_err_d = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                // No arbitration here so a still-held request is not served twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_DMA;
            cnt_q         <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            cpu_r_q       <= 1'b0;
            dma_ack_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            cpu_r_q       <= cpu_r_d;
            dma_ack_q     <= dma_ack_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_r       = cpu_r_q;
    assign dma_rdata   = dma_rdata_q;
    assign dma_ack     = dma_ack_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench for lc3_mem_arbiter with TIMEOUT = 4.
module tb_lc3_mem_arbiter;

    localparam int TO = 4;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          rdy_at;    // BUSY cycle index carrying mem_rdy; >= TO means never
        logic [15:0] mdata;
        logic [15:0] exp_rdata; // owner's rdata after the access
        logic        exp_to;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mio_en, cpu_r_w, cpu_r;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_ack;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_en, mem_we, mem_rdy, timeout_err, busy;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[9];

    always #5 clk = ~clk;

    lc3_mem_arbiter #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cpu_mio_en  (cpu_mio_en),
        .cpu_r_w     (cpu_r_w),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_r       (cpu_r),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_rdata   (dma_rdata),
        .dma_ack     (dma_ack),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_rdy     (mem_rdy),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cpu_mio_en = 1'b0; cpu_r_w = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_rdy = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        check1("rst mem_en", mem_en, 1'b0);
        check1("rst busy", busy, 1'b0);
        check1("rst cpu_r", cpu_r, 1'b0);
        check1("rst dma_ack", dma_ack, 1'b0);
        check1("rst timeout_err", timeout_err, 1'b0);
        check16("rst mem_addr", mem_addr, 16'h0000);
        check16("rst cpu_rdata", cpu_rdata, 16'h0000);
        check16("rst dma_rdata", dma_rdata, 16'h0000);
        reset_n = 1'b1;
    endtask

    // One isolated access from IDLE with only the vector's requester active.
    task automatic run_vec(input vec_t v);
        int n_busy;
        n_busy = v.exp_to ? TO : v.rdy_at + 1;
        if (v.is_dma) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
        end else begin
            cpu_mio_en = 1'b1; cpu_r_w = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        end
        mem_rdy = 1'b0;
        mem_rdata = v.mdata;
        tick();
        check1("grant mem_en", mem_en, 1'b1);
        check16("grant mem_addr", mem_addr, v.addr);
        check1("grant mem_we", mem_we, v.we);
        check16("grant mem_wdata", mem_wdata, v.wdata);
        check1("grant busy", busy, 1'b1);
        for (int i = 0; i < n_busy; i++) begin
            mem_rdy = (i == v.rdy_at);
            tick();
            if (i < n_busy - 1) begin
                check1("wait mem_en", mem_en, 1'b1);
                check1("wait ready", cpu_r | dma_ack, 1'b0);
            end
        end
        mem_rdy = 1'b0;
        cpu_mio_en = 1'b0;
        dma_req = 1'b0;
        check1("resp mem_en", mem_en, 1'b0);
        check1("resp cpu_r", cpu_r, !v.is_dma);
        check1("resp dma_ack", dma_ack, v.is_dma);
        check1("resp timeout_err", timeout_err, v.exp_to);
        check1("resp busy", busy, 1'b1);
        check16("resp rdata", v.is_dma ? dma_rdata : cpu_rdata, v.exp_rdata);
        tick();
        check1("idle cpu_r", cpu_r, 1'b0);
        check1("idle dma_ack", dma_ack, 1'b0);
        check1("idle timeout_err", timeout_err, 1'b0);
        check1("idle busy", busy, 1'b0);
        check1("idle mem_en", mem_en, 1'b0);
    endtask

    initial begin
        vec_t v;
        // is_dma we addr wdata rdy_at mdata exp_rdata exp_to
        vecs[0] = '{1'b0, 1'b0, 16'h3000, 16'h0000, 2,  16'h1234, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'hFE06, 16'h0041, 0,  16'hDEAD, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h4000, 16'hBEEF, 1,  16'hDEAD, 16'h1234, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'h1000, 16'h0000, 3,  16'h5A5A, 16'h5A5A, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 99, 16'hABCD, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 1,  16'h7777, 16'h7777, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 16'h0050, 16'h1111, 99, 16'hDEAD, 16'h0000, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 16'h0060, 16'h0000, 0,  16'hCAFE, 16'hCAFE, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 16'h0070, 16'h2222, 3,  16'hDEAD, 16'hCAFE, 1'b0};

        do_reset();

        // Tie from reset: CPU first, then strict alternation with both holding.
        cpu_mio_en = 1'b1; cpu_r_w = 1'b0; cpu_addr = 16'h1111;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h2222; dma_wdata = 16'h3333;
        for (int j = 0; j < 4; j++) begin
            tick();
            check1("tie mem_en", mem_en, 1'b1);
            check16("tie mem_addr", mem_addr, (j % 2 == 0) ? 16'h1111 : 16'h2222);
            check1("tie mem_we", mem_we, (j % 2 != 0));
            mem_rdy = 1'b1;
            mem_rdata = 16'h00A0;
            tick();
            check1("tie cpu_r", cpu_r, (j % 2 == 0));
            check1("tie dma_ack", dma_ack, (j % 2 != 0));
            mem_rdy = 1'b0;
            tick();
            check1("tie idle busy", busy, 1'b0);
        end

        do_reset();
        for (int k = 0; k < 9; k++) begin
            run_vec(vecs[k]);
        end

        // DMA write whose address changes after grant; command must stay frozen.
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'hFE06; dma_wdata = 16'h0041;
        mem_rdata = 16'hDEAD;
        tick();
        dma_addr = 16'h0000; dma_wdata = 16'h0000;
        tick();
        check16("dmaw mem_addr", mem_addr, 16'hFE06);
        check1("dmaw mem_we", mem_we, 1'b1);
        check16("dmaw mem_wdata", mem_wdata, 16'h0041);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        check1("dmaw dma_ack", dma_ack, 1'b1);
        check1("dmaw cpu_r", cpu_r, 1'b0);
        check16("dmaw dma_rdata", dma_rdata, 16'h0000);
        dma_req = 1'b0;
        tick();
        check1("dmaw ack once", dma_ack, 1'b0);

        // CPU holds its request through RESP; must not be served again.
        cpu_mio_en = 1'b1; cpu_r_w = 1'b0; cpu_addr = 16'h0123;
        tick();
        check1("nodbl mem_en", mem_en, 1'b1);
        mem_rdy = 1'b1; mem_rdata = 16'h4444;
        tick();
        mem_rdy = 1'b0;
        check1("nodbl cpu_r", cpu_r, 1'b1);
        check16("nodbl cpu_rdata", cpu_rdata, 16'h4444);
        tick();
        check1("nodbl no regrant", mem_en, 1'b0);
        check1("nodbl busy", busy, 1'b0);
        cpu_mio_en = 1'b0;
        tick();
        check1("nodbl still idle", mem_en, 1'b0);

        // Reset during BUSY, then a late mem_rdy.
        cpu_mio_en = 1'b1; cpu_r_w = 1'b0; cpu_addr = 16'h0200;
        tick();
        check1("rmid mem_en", mem_en, 1'b1);
        tick();
        reset_n = 1'b0;
        cpu_mio_en = 1'b0;
        tick();
        check1("rmid mem_en low", mem_en, 1'b0);
        check1("rmid busy low", busy, 1'b0);
        reset_n = 1'b1;
        mem_rdy = 1'b1; mem_rdata = 16'h9999;
        tick();
        mem_rdy = 1'b0;
        check1("late mem_en", mem_en, 1'b0);
        check1("late cpu_r", cpu_r, 1'b0);
        check1("late dma_ack", dma_ack, 1'b0);
        check1("late timeout_err", timeout_err, 1'b0);
        check1("late busy", busy, 1'b0);
        check16("late cpu_rdata", cpu_rdata, 16'h0000);
        v = '{1'b0, 1'b0, 16'h0300, 16'h0000, 1, 16'h5555, 16'h5555, 1'b0};
        run_vec(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
